// File: rtl/corr_window_feeder_pkg.sv
// Shared definitions for the correlator window feeder: default geometry,
// FSM state encoding and counter sizing helper.
package corr_window_feeder_pkg;

    localparam int TAPS_DEF     = 10;
    localparam int SAMPLE_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_COEF = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    // Wide enough to hold the value n itself, not just n-1.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/corr_window_feeder_window_shift_reg.sv
// Sample window: x_0 (newest) sits in the low slice; each shift moves x_k-1 into x_k.
module window_shift_reg #(
    parameter int TAPS     = 10,
    parameter int SAMPLE_W = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     shift_en,
    input  logic                     clear,
    input  logic [SAMPLE_W-1:0]      din,
    output logic [TAPS*SAMPLE_W-1:0] win
);

    logic [TAPS*SAMPLE_W-1:0] win_q, win_d;

    always_comb begin
        win_d = win_q;
        if (clear) begin
            win_d = '0;
        end else if (shift_en) begin
            win_d = {win_q[(TAPS-1)*SAMPLE_W-1:0], din};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            win_q <= '0;
        end else begin
            win_q <= win_d;
        end
    end

    assign win = win_q;

endmodule

// File: rtl/corr_window_feeder.sv
// Streaming front end for the correlator: serial coefficient loader, sliding
// sample window and a one-cycle win_valid pulse per fresh window.
module corr_window_feeder
    import corr_window_feeder_pkg::*;
#(
    parameter int TAPS     = TAPS_DEF,
    parameter int SAMPLE_W = SAMPLE_W_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     coef_load,
    input  logic [SAMPLE_W-1:0]      coef_in,
    input  logic                     coef_valid,
    output logic                     coef_done,
    input  logic [SAMPLE_W-1:0]      samp_in,
    input  logic                     samp_valid,
    output logic                     samp_ready,
    input  logic                     flush,
    output logic [TAPS*SAMPLE_W-1:0] x_win,
    output logic [TAPS*SAMPLE_W-1:0] h_taps,
    output logic                     win_valid
);

    localparam int CNT_W = cnt_width(TAPS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TAPS - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     coef_cnt_q, coef_cnt_d;
    logic [CNT_W-1:0]     fill_cnt_q, fill_cnt_d;
    logic [SAMPLE_W-1:0]  h_q [TAPS];
    logic [SAMPLE_W-1:0]  h_d [TAPS];
    logic                 coef_done_q, coef_done_d;
    logic                 win_valid_q, win_valid_d;
    logic                 accept;
    logic                 win_clear;

    // samp_ready already masks coef_load and flush, so an accept never
    // coincides with a higher-priority control action.
    assign samp_ready = (state_q != ST_COEF) & ~flush & ~coef_load;
    assign accept     = samp_valid & samp_ready;
    assign win_clear  = coef_load | (flush & (state_q != ST_COEF));

    always_comb begin
        state_d     = state_q;
        coef_cnt_d  = coef_cnt_q;
        fill_cnt_d  = fill_cnt_q;
        h_d         = h_q;
        coef_done_d = coef_done_q;
        win_valid_d = 1'b0;
        if (coef_load) begin
            state_d     = ST_COEF;
            coef_cnt_d  = '0;
            fill_cnt_d  = '0;
            coef_done_d = 1'b0;
        end else begin
            case (state_q)
                ST_COEF: begin
                    if (coef_valid) begin
                        for (int k = 0; k < TAPS; k++) begin
                            if (coef_cnt_q == CNT_W'(k)) h_d[k] = coef_in;
                        end
                        coef_cnt_d = coef_cnt_q + ONE;
                        if (coef_cnt_q == LAST) begin
                            coef_done_d = 1'b1;
                            state_d     = ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    if (flush) begin
                        fill_cnt_d = '0;
                    end else if (accept) begin
                        fill_cnt_d = fill_cnt_q + ONE;
                        if (fill_cnt_q == LAST) begin
                            state_d     = ST_RUN;
                            win_valid_d = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        fill_cnt_d = '0;
                        state_d    = ST_FILL;
                    end else if (accept) begin
                        win_valid_d = 1'b1;
                    end
                end
                default: state_d = ST_COEF;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_COEF;
            coef_cnt_q  <= '0;
            fill_cnt_q  <= '0;
            h_q         <= '{default: '0};
            coef_done_q <= 1'b0;
            win_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            coef_cnt_q  <= coef_cnt_d;
            fill_cnt_q  <= fill_cnt_d;
            h_q         <= h_d;
            coef_done_q <= coef_done_d;
            win_valid_q <= win_valid_d;
        end
    end

    for (genvar k = 0; k < TAPS; k++) begin : g_h_flat
        assign h_taps[k*SAMPLE_W +: SAMPLE_W] = h_q[k];
    end

    window_shift_reg #(
        .TAPS     (TAPS),
        .SAMPLE_W (SAMPLE_W)
    ) u_window (
        .clock    (clock),
        .reset    (reset),
        .shift_en (accept),
        .clear    (win_clear),
        .din      (samp_in),
        .win      (x_win)
    );

    assign coef_done = coef_done_q;
    assign win_valid = win_valid_q;

endmodule
